// File: rtl/zuss_alu_issue_if.sv
// Request/response handshake bundle between the ZUSS decode stage, the ALU issue
// stage and writeback. The issue stage uses the slave view, its environment the master view.
interface zuss_alu_issue_if #(
    parameter int W   = 32,
    parameter int OPW = 5
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [3:0]     rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_flags
    );
endinterface

// File: rtl/zuss_alu_issue.sv
// Sequential issue/retire wrapper around the combinational ZUSS ALU (IDLE -> EXEC -> HOLD).
// Optional ZUSS_ALU_ISSUE_STATS_EN adds saturating op/exception counters on the response side.
module zuss_alu_issue #(
    parameter int W   = 32,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    zuss_alu_issue_if.slave bus,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_out
`ifdef ZUSS_ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]    stat_ops,
    output logic [15:0]    stat_exc
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(7);
    localparam logic [OPW-1:0] OP_LSL  = OPW'(8);
    localparam logic [OPW-1:0] OP_LSR  = OPW'(9);
    localparam logic [OPW-1:0] OP_LAST = OPW'(9);
    localparam logic [W-1:0]   SHIFT_LIM = W'(W);

    logic [1:0]     state_q,     state_d;
    logic [W-1:0]   alu_a_q,     alu_a_d;
    logic [W-1:0]   alu_b_q,     alu_b_d;
    logic [OPW-1:0] alu_op_q,    alu_op_d;
    logic [W-1:0]   rsp_data_q,  rsp_data_d;
    logic [3:0]     rsp_flags_q, rsp_flags_d;

    logic           req_ready_w;
    logic           rsp_valid_w;
    logic           take_req;
    logic [W-1:0]   exec_data;
    logic           exec_dz;
    logic           exec_err;
    logic [3:0]     exec_flags;

    // Exceptional operands replace whatever the ALU produced for them.
    always_comb begin
        exec_data = alu_out;
        exec_dz   = 1'b0;
        exec_err  = 1'b0;
        if (alu_op_q > OP_LAST) begin
            exec_data = '0;
            exec_err  = 1'b1;
        end else if (alu_op_q == OP_DIV && alu_b_q == '0) begin
            exec_data = '1;
            exec_dz   = 1'b1;
        end else if ((alu_op_q == OP_LSL || alu_op_q == OP_LSR) && alu_b_q >= SHIFT_LIM) begin
            exec_data = '0;
        end
    end

    assign exec_flags = {exec_err, exec_dz, exec_data[W-1], (exec_data == '0)};

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        req_ready_w = 1'b0;
        rsp_valid_w = 1'b0;
        take_req    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_w = 1'b1;
                if (bus.req_valid) begin
                    take_req = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = exec_data;
                rsp_flags_d = exec_flags;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                rsp_valid_w = 1'b1;
                // A retiring result frees the stage in the same cycle, so a new op may follow it.
                req_ready_w = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    take_req = bus.req_valid;
                    state_d  = bus.req_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_req) begin
            alu_a_d  = bus.req_a;
            alu_b_d  = bus.req_b;
            alu_op_d = bus.req_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_MOV;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;

`ifdef ZUSS_ALU_ISSUE_STATS_EN
    logic        rsp_fire;
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [15:0] stat_exc_q, stat_exc_d;

    assign rsp_fire = rsp_valid_w & bus.rsp_ready;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_exc_d = stat_exc_q;
        if (rsp_fire) begin
            if (stat_ops_q != '1) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end
            if ((rsp_flags_q[3] | rsp_flags_q[2]) && stat_exc_q != '1) begin
                stat_exc_d = stat_exc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q <= '0;
            stat_exc_q <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_exc_q <= stat_exc_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_exc = stat_exc_q;
`endif

endmodule

// File: tb/tb_zuss_alu_issue.sv
// Self-checking bench for zuss_alu_issue: vector table plus scoreboard, with a behavioural
// ALU model standing in for the real combinational ALU.
module tb_zuss_alu_issue;
    localparam int W   = 32;
    localparam int OPW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zuss_alu_issue_if #(.W(W), .OPW(OPW)) bus ();

    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_out;
    logic [OPW-1:0] alu_op;
`ifdef ZUSS_ALU_ISSUE_STATS_EN
    logic [31:0] stat_ops;
    logic [15:0] stat_exc;
    int          hs_ops = 0;
    int          hs_exc = 0;
`endif

    zuss_alu_issue #(.W(W), .OPW(OPW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_out (alu_out)
`ifdef ZUSS_ALU_ISSUE_STATS_EN
        ,
        .stat_ops(stat_ops),
        .stat_exc(stat_exc)
`endif
    );

    // Hardware-like ALU: masks shift amounts and returns junk for illegal ops / div by 0,
    // so the issue stage's overrides are observable.
    always_comb begin
        case (alu_op)
            5'd0:    alu_out = alu_a + alu_b;
            5'd1:    alu_out = alu_a - alu_b;
            5'd2:    alu_out = alu_a * alu_b;
            5'd3:    alu_out = (alu_b == 32'd0) ? 32'h0000_1234 : alu_a / alu_b;
            5'd4:    alu_out = alu_a | alu_b;
            5'd5:    alu_out = alu_a & alu_b;
            5'd6:    alu_out = ~alu_a;
            5'd7:    alu_out = alu_a;
            5'd8:    alu_out = alu_a << alu_b[4:0];
            5'd9:    alu_out = alu_a >> alu_b[4:0];
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [35:0] exp_q[$];
    int rsp_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Expected {err, dz, n, z, data} from the architectural definition.
    function automatic logic [35:0] ref_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic dz;
        logic err;
        dz = 1'b0;
        err = 1'b0;
        case (op)
            5'd0: d = a + b;
            5'd1: d = a - b;
            5'd2: d = a * b;
            5'd3: if (b == 32'd0) begin d = 32'hFFFF_FFFF; dz = 1'b1; end else d = a / b;
            5'd4: d = a | b;
            5'd5: d = a & b;
            5'd6: d = ~a;
            5'd7: d = a;
            5'd8: d = (b >= 32'd32) ? 32'd0 : (a << b);
            5'd9: d = (b >= 32'd32) ? 32'd0 : (a >> b);
            default: begin d = 32'd0; err = 1'b1; end
        endcase
        return {err, dz, d[31], (d == 32'd0), d};
    endfunction

    // Response monitor: every rsp handshake pops and compares one expected record.
    always @(negedge clk) begin
        if (!rst_n) begin
`ifdef ZUSS_ALU_ISSUE_STATS_EN
            hs_ops = 0;
            hs_exc = 0;
`endif
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_unexpected: got data %0h flags %0h, required no response",
                         bus.rsp_data, bus.rsp_flags);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                check("rsp", {bus.rsp_flags, bus.rsp_data}, e);
                rsp_cyc_q.push_back(cyc);
`ifdef ZUSS_ALU_ISSUE_STATS_EN
                hs_ops++;
                if (e[35] | e[34]) hs_exc++;
`endif
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 just after the request handshake edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [35:0] e);
        int tries;
        tries = 0;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        forever begin
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(e);
                break;
            end
            tries++;
            if (tries > 200) begin
                n_vec++;
                n_bad++;
                $display("FAIL req_timeout: got req_ready=0 for %0d cycles, required 1", tries);
                break;
            end
        end
        @(posedge clk);
        #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [3:0]  f;
    } vec_t;

    vec_t tv[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{5'd0,  32'd5,          32'd7,          32'd12,         4'b0000};
        tv[1]  = '{5'd1,  32'd3,          32'd3,          32'd0,          4'b0001};
        tv[2]  = '{5'd1,  32'd0,          32'd1,          32'hFFFF_FFFF,  4'b0010};
        tv[3]  = '{5'd3,  32'd10,         32'd0,          32'hFFFF_FFFF,  4'b0110};
        tv[4]  = '{5'd9,  32'd8,          32'd40,         32'd0,          4'b0001};
        tv[5]  = '{5'd2,  32'h0001_0000,  32'h0001_0000,  32'd0,          4'b0001};
        tv[6]  = '{5'd2,  32'd7,          32'd6,          32'd42,         4'b0000};
        tv[7]  = '{5'd3,  32'd100,        32'd7,          32'd14,         4'b0000};
        tv[8]  = '{5'd3,  32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  4'b0000};
        tv[9]  = '{5'd4,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  4'b0000};
        tv[10] = '{5'd5,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  4'b0000};
        tv[11] = '{5'd6,  32'd0,          32'd9,          32'hFFFF_FFFF,  4'b0010};
        tv[12] = '{5'd7,  32'h8000_0000,  32'd3,          32'h8000_0000,  4'b0010};
        tv[13] = '{5'd8,  32'd1,          32'd31,         32'h8000_0000,  4'b0010};
        tv[14] = '{5'd8,  32'd1,          32'd33,         32'd0,          4'b0001};
        tv[15] = '{5'd8,  32'd1,          32'd32,         32'd0,          4'b0001};
        tv[16] = '{5'd9,  32'h8000_0000,  32'd31,         32'd1,          4'b0000};
        tv[17] = '{5'd12, 32'd5,          32'd5,          32'd0,          4'b1001};
        tv[18] = '{5'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          4'b0001};
        tv[19] = '{5'd31, 32'd1,          32'd1,          32'd0,          4'b1001};

        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp", 64'({bus.rsp_flags, bus.rsp_data}), 64'd0);
        check("rst_alu", 64'({alu_op, alu_a, alu_b}), {5'd7, 32'd0, 32'd0});
        @(posedge clk);
        #2;

        // Latency: handshake at edge N, rsp_valid seen high for the N+2 edge
        send(5'd0, 32'd5, 32'd7, {4'b0000, 32'd12});
        @(negedge clk);
        check("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("exec_req_ready", 64'(bus.req_ready), 64'd0);
        check("exec_alu", 64'({alu_op, alu_a, alu_b}), {5'd0, 32'd5, 32'd7});
        @(negedge clk);
        check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk);
        #2;
        wait_drain();

        // Vector table, back to back
        for (int i = 0; i < 20; i++) begin
            send(tv[i].op, tv[i].a, tv[i].b, {tv[i].f, tv[i].d});
        end
        wait_drain();

        // Backpressure: result held stable, a waiting request is ignored
        bus.rsp_ready = 1'b0;
        send(5'd1, 32'd3, 32'd3, {4'b0001, 32'd0});
        bus.req_valid = 1'b1;
        bus.req_op = 5'd0;
        bus.req_a = 32'd1;
        bus.req_b = 32'd1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp", 64'({bus.rsp_valid, bus.rsp_flags, bus.rsp_data}), {1'b1, 4'b0001, 32'd0});
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            check("bp_alu_a", 64'(alu_a), 64'd3);
        end
        @(posedge clk);
        #2;
        rsp_cyc_q.delete();
        bus.rsp_ready = 1'b1;
        send(5'd0, 32'd1, 32'd1, ref_calc(5'd0, 32'd1, 32'd1));
        send(5'd2, 32'd6, 32'd7, ref_calc(5'd2, 32'd6, 32'd7));
        wait_drain();
        check("b2b_count", 64'(rsp_cyc_q.size()), 64'd3);
        if (rsp_cyc_q.size() == 3) begin
            check("b2b_gap0", 64'(rsp_cyc_q[1] - rsp_cyc_q[0]), 64'd2);
            check("b2b_gap1", 64'(rsp_cyc_q[2] - rsp_cyc_q[1]), 64'd2);
        end

        // Reset while in EXEC discards the op; first op after reset is an illegal opcode
        send(5'd3, 32'd100, 32'd7, ref_calc(5'd3, 32'd100, 32'd7));
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("arst_alu_op", 64'(alu_op), 64'd7);
        check("arst_rsp", 64'({bus.rsp_flags, bus.rsp_data}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(5'd12, 32'd5, 32'd5, {4'b1001, 32'd0});
        wait_drain();
`ifdef ZUSS_ALU_ISSUE_STATS_EN
        check("stat_ops_first", 64'(stat_ops), 64'd1);
        check("stat_exc_first", 64'(stat_exc), 64'd1);
`endif

        // Random ops with random response stalls
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 5'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            send(op, a, b, ref_calc(op, a, b));
            bus.rsp_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            bus.rsp_ready = 1'b1;
        end
        wait_drain();
`ifdef ZUSS_ALU_ISSUE_STATS_EN
        check("stat_ops_final", 64'(stat_ops), 64'(hs_ops));
        check("stat_exc_final", 64'(stat_exc), 64'(hs_exc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
